free_list: RTL and testbench
============================

Name: free_list

Overview:
- Circular FIFO of free physical register indices for the rename path.
- Dispatch dequeues one tag per cycle as the destination tag. The reorder buffer returns retired Told tags through enqueue.
- A single head checkpoint supports branch-mispredict rollback: tags handed out after the checkpoint are reclaimed by restoring the head pointer.

Parameters:
- NUM_PREGS, 64, total physical registers; power of two; also the FIFO depth.
- NUM_AREGS, 32, architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset.
- IDX_W, $clog2(NUM_PREGS), physical register index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dequeue_en  in  1  dispatch consumes free_preg this cycle
- free_preg  out  IDX_W  tag at head (combinational from head entry)
- empty  out  1  no free tag available
- enqueue_en  in  1  ROB retire frees a tag (driven by update_free_list)
- enqueue_preg  in  IDX_W  tag being freed (driven by free_index)
- checkpoint_en  in  1  snapshot head pointer (branch dispatch)
- rollback  in  1  restore head from snapshot (mispredict)
- free_count  out  IDX_W+1  number of free tags
- overflow  out  1  sticky: enqueue attempted while full

Behaviour:
- Storage: NUM_PREGS entries of IDX_W bits. Pointers head and tail are IDX_W+1 bits (extra wrap bit).
- free_count = tail - head (IDX_W+1-bit modular). empty = (free_count == 0). full = (free_count == NUM_PREGS).
- Reset (sync, highest priority):
  - entry[i] = NUM_AREGS + i for i < NUM_PREGS-NUM_AREGS.
  - head = 0; tail = NUM_PREGS-NUM_AREGS; checkpoint = 0; overflow = 0.
  - After reset: free_preg = NUM_AREGS, free_count = NUM_PREGS-NUM_AREGS, empty = 0.
- Dequeue: if dequeue_en && !empty && !rollback, then head <= head+1. The tag on free_preg in that cycle is the one consumed (zero latency). dequeue_en while empty is ignored; head is unchanged.
- Enqueue: if enqueue_en && enqueue_preg != 0 && !full, then entry[tail] <= enqueue_preg and tail <= tail+1.
  - enqueue_preg == 0 (zero register) is silently dropped.
  - Enqueue while full is dropped and sets overflow (sticky until reset).
- No bypass: a tag enqueued in cycle N is visible on free_preg no earlier than N+1. If empty, a simultaneous dequeue is ignored even when enqueue is active.
- Enqueue+dequeue, same cycle, non-empty and non-full: both apply; free_count is unchanged.
- Checkpoint: checkpoint_en loads the head value after this cycle's dequeue (the next head).
- Rollback: head <= checkpoint. This cycle's dequeue is ignored. Enqueue still applies; tail is never rolled back.
- Rollback + checkpoint_en, same cycle: rollback applies and the checkpoint loads the restored value.
- Wrap: pointers wrap modulo 2*NUM_PREGS. The storage index is the low IDX_W bits.
- Reset asserted mid-stream overrides all other inputs in that cycle.

Test Plan:
- Reset with defaults -> free_preg=32, free_count=32, empty=0, overflow=0.
- 32 consecutive dequeues -> free_preg sequence 32..63; then empty=1, free_count=0. A 33rd dequeue leaves head unchanged.
- From empty: enqueue tag 40 with dequeue_en=1 in the same cycle -> dequeue ignored. Next cycle free_preg=40, free_count=1.
- Checkpoint after 3 dequeues (free_preg=35). Dequeue 4 more, enqueue tag 7 with rollback in the same cycle -> free_preg=35, free_count=30 (29+1).
- Enqueue tag 0 -> tail and free_count unchanged. Fill to 64, enqueue tag 9 -> dropped, overflow=1, stays 1 until reset.
- Run 200 cycles of random balanced enqueue/dequeue across the wrap boundary against a scoreboard queue -> FIFO order and free_count match every cycle.

Source files
------------

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module      : free_list
//  Description : Circular FIFO of free physical register tags for rename.
//                Dispatch pops one tag per cycle from the head, and retire
//                pushes released tags at the tail. A single head checkpoint
//                lets a branch mispredict give back every tag handed out
//                since the checkpoint was taken.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   system clock
//    reset          in   synchronous, active-high reset
//    dequeue_en     in   dispatch consumes free_preg this cycle
//    free_preg      out  tag at the head (combinational from the head entry)
//    empty          out  no free tag available
//    enqueue_en     in   retire frees a tag
//    enqueue_preg   in   tag being freed (tag 0 is dropped)
//    checkpoint_en  in   snapshot the next head pointer
//    rollback       in   restore the head from the snapshot
//    free_count     out  number of free tags
//    overflow       out  sticky: a non-zero enqueue was attempted while full
// ============================================================================
module free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int IDX_W     = $clog2(NUM_PREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dequeue_en,
  output logic [IDX_W-1:0] free_preg,
  output logic             empty,
  input  logic             enqueue_en,
  input  logic [IDX_W-1:0] enqueue_preg,
  input  logic             checkpoint_en,
  input  logic             rollback,
  output logic [IDX_W:0]   free_count,
  output logic             overflow
);

  localparam int          PTR_W    = IDX_W + 1;
  localparam int          NUM_FREE = NUM_PREGS - NUM_AREGS;
  localparam [PTR_W-1:0]  C_TAIL_RST = PTR_W'(NUM_FREE);
  localparam [PTR_W-1:0]  C_FULL_CNT = PTR_W'(NUM_PREGS);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W-1:0] mem_q [NUM_PREGS];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] ckpt_q, ckpt_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_enq_req;
  logic             w_do_enq;
  logic             w_do_deq;

  assign w_count   = tail_q - head_q;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == C_FULL_CNT);

  // The zero register is never a valid free tag, so it is filtered here.
  assign w_enq_req = enqueue_en && (enqueue_preg != '0);
  assign w_do_enq  = w_enq_req && !w_full;
  // No bypass: emptiness is judged on the current state, so a same-cycle
  // enqueue cannot satisfy a dequeue.
  assign w_do_deq  = dequeue_en && !w_empty && !rollback;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ckpt_d     = ckpt_q;
    overflow_d = overflow_q;

    if (rollback) begin
      head_d = ckpt_q;
    end else if (w_do_deq) begin
      head_d = head_q + PTR_W'(1);
    end

    if (w_do_enq) begin
      tail_d = tail_q + PTR_W'(1);
    end

    // The snapshot takes the post-update head so that a checkpoint issued
    // alongside a dequeue (or a rollback) captures the head dispatch will
    // see next.
    if (checkpoint_en) begin
      ckpt_d = head_d;
    end

    if (w_enq_req && w_full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        if (i < NUM_FREE) begin
          mem_q[i] <= IDX_W'(NUM_AREGS + i);
        end else begin
          mem_q[i] <= '0;
        end
      end
      head_q     <= '0;
      tail_q     <= C_TAIL_RST;
      ckpt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_do_enq) begin
        mem_q[tail_q[IDX_W-1:0]] <= enqueue_preg;
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      ckpt_q     <= ckpt_d;
      overflow_q <= overflow_d;
    end
  end

  assign free_preg  = mem_q[head_q[IDX_W-1:0]];
  assign empty      = w_empty;
  assign free_count = w_count;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_free_list
//  Description : Directed and scoreboard-driven checks of free_list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_free_list;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int IDX_W     = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             dequeue_en;
  logic [IDX_W-1:0] free_preg;
  logic             empty;
  logic             enqueue_en;
  logic [IDX_W-1:0] enqueue_preg;
  logic             checkpoint_en;
  logic             rollback;
  logic [IDX_W:0]   free_count;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  free_list #(
    .NUM_PREGS(NUM_PREGS),
    .NUM_AREGS(NUM_AREGS),
    .IDX_W    (IDX_W)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .dequeue_en   (dequeue_en),
    .free_preg    (free_preg),
    .empty        (empty),
    .enqueue_en   (enqueue_en),
    .enqueue_preg (enqueue_preg),
    .checkpoint_en(checkpoint_en),
    .rollback     (rollback),
    .free_count   (free_count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dequeue_en    = 1'b0;
    enqueue_en    = 1'b0;
    enqueue_preg  = '0;
    checkpoint_en = 1'b0;
    rollback      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (free_preg !== 6'd32) begin n_bad++; $display("FAIL rst_free_preg got %0d want 32", free_preg); end
    n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL rst_free_count got %0d want 32", free_count); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL rst_empty got %0b want 0", empty); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if (free_preg !== 6'(32 + k)) begin
        n_bad++; $display("FAIL drain_seq[%0d] got %0d want %0d", k, free_preg, 32 + k);
      end
      dequeue_en = 1'b1;
      tick();
    end
    idle();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %0b want 1", empty); end
    n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL drain_count got %0d want 0", free_count); end
    dequeue_en = 1'b1;
    tick();
    idle();
    n_cmp++; if (free_count !== 7'd0) begin n_bad++; $display("FAIL deq_empty_count got %0d want 0", free_count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL deq_empty_empty got %0b want 1", empty); end
  endtask

  // Runs straight after test_drain: the list is empty here.
  task automatic test_no_bypass();
    enqueue_en   = 1'b1;
    enqueue_preg = 6'd40;
    dequeue_en   = 1'b1;
    tick();
    idle();
    n_cmp++; if (free_preg !== 6'd40) begin n_bad++; $display("FAIL nobyp_free_preg got %0d want 40", free_preg); end
    n_cmp++; if (free_count !== 7'd1) begin n_bad++; $display("FAIL nobyp_count got %0d want 1", free_count); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL nobyp_empty got %0b want 0", empty); end
  endtask

  task automatic test_rollback();
    do_reset();
    // Three dequeues; checkpoint rides on the third, capturing head = 3.
    for (int k = 0; k < 3; k++) begin
      dequeue_en    = 1'b1;
      checkpoint_en = (k == 2);
      tick();
    end
    idle();
    n_cmp++; if (free_preg !== 6'd35) begin n_bad++; $display("FAIL ckpt_free_preg got %0d want 35", free_preg); end
    for (int k = 0; k < 4; k++) begin
      dequeue_en = 1'b1;
      tick();
    end
    idle();
    n_cmp++; if (free_count !== 7'd25) begin n_bad++; $display("FAIL pre_rb_count got %0d want 25", free_count); end
    // Rollback with an enqueue of tag 7 and a dequeue request that must be ignored.
    rollback     = 1'b1;
    dequeue_en   = 1'b1;
    enqueue_en   = 1'b1;
    enqueue_preg = 6'd7;
    tick();
    idle();
    n_cmp++; if (free_preg !== 6'd35) begin n_bad++; $display("FAIL rb_free_preg got %0d want 35", free_preg); end
    n_cmp++; if (free_count !== 7'd30) begin n_bad++; $display("FAIL rb_count got %0d want 30", free_count); end
    // Two more dequeues (head 5), then rollback + checkpoint: snapshot must be 3.
    dequeue_en = 1'b1;
    tick();
    tick();
    idle();
    rollback      = 1'b1;
    checkpoint_en = 1'b1;
    dequeue_en    = 1'b1;
    tick();
    idle();
    n_cmp++; if (free_preg !== 6'd35) begin n_bad++; $display("FAIL rbck_free_preg got %0d want 35", free_preg); end
    dequeue_en = 1'b1;
    tick();
    idle();
    n_cmp++; if (free_preg !== 6'd36) begin n_bad++; $display("FAIL rbck_deq got %0d want 36", free_preg); end
    rollback = 1'b1;
    tick();
    idle();
    n_cmp++; if (free_preg !== 6'd35) begin n_bad++; $display("FAIL rbck_restore got %0d want 35", free_preg); end
  endtask

  task automatic test_zero_overflow();
    do_reset();
    enqueue_en   = 1'b1;
    enqueue_preg = 6'd0;
    tick();
    idle();
    n_cmp++; if (free_count !== 7'd32) begin n_bad++; $display("FAIL zero_count got %0d want 32", free_count); end
    for (int k = 1; k <= 32; k++) begin
      enqueue_en   = 1'b1;
      enqueue_preg = 6'(k);
      tick();
    end
    idle();
    n_cmp++; if (free_count !== 7'd64) begin n_bad++; $display("FAIL fill_count got %0d want 64", free_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow got %0b want 0", overflow); end
    enqueue_en   = 1'b1;
    enqueue_preg = 6'd9;
    tick();
    idle();
    n_cmp++; if (free_count !== 7'd64) begin n_bad++; $display("FAIL ovf_count got %0d want 64", free_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0b want 1", overflow); end
    // Drain the 32 reset tags; the next tag must be 1 (tag 0 never landed).
    for (int k = 0; k < 32; k++) begin
      dequeue_en = 1'b1;
      tick();
    end
    idle();
    n_cmp++; if (free_preg !== 6'd1) begin n_bad++; $display("FAIL zero_drop_order got %0d want 1", free_preg); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    do_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %0b want 0", overflow); end
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] q[$];
    logic             deq, enq;
    logic [IDX_W-1:0] tag;
    int               sz;
    do_reset();
    for (int k = 0; k < 32; k++) q.push_back(6'(32 + k));
    for (int c = 0; c < 200; c++) begin
      sz = q.size();
      n_cmp++; if (free_count !== 7'(sz)) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, free_count, sz); end
      n_cmp++; if (empty !== (sz == 0)) begin n_bad++; $display("FAIL rnd_empty[%0d] got %0b want %0b", c, empty, sz == 0); end
      if (sz > 0) begin
        n_cmp++; if (free_preg !== q[0]) begin n_bad++; $display("FAIL rnd_free_preg[%0d] got %0d want %0d", c, free_preg, q[0]); end
      end
      deq = 1'($urandom_range(0, 1));
      enq = 1'($urandom_range(0, 1));
      tag = 6'($urandom_range(1, 63));
      dequeue_en   = deq;
      enqueue_en   = enq;
      enqueue_preg = tag;
      if (deq && sz > 0) void'(q.pop_front());
      if (enq && sz < NUM_PREGS) q.push_back(tag);
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_drain();
    test_no_bypass();
    test_rollback();
    test_zero_overflow();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
